// File: rtl/store_buffer_ctrl.sv
// Store buffer and drain scheduler sitting between the MEM stage and the
// single-port data SRAM. Stores are converted to lane-aligned data and an
// active-low bit-write mask on entry, queued in a FIFO and written to the
// SRAM whenever the load path leaves the port free.
module store_buffer_ctrl #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       st_valid,
   output logic                       st_ready,
   input  logic [2:0]                 st_funct3,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [31:0]                st_data,
   input  logic                       ld_check_valid,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       ld_stall,
   input  logic                       flush_req,
   output logic                       drain_done,
   input  logic                       mem_grant,
   output logic                       mem_web,
   output logic [31:0]                mem_bweb,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [31:0]                mem_wdata,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = ADDR_W - 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic          flush_prev_q, flush_prev_d;

   logic [WW-1:0] ent_addr_q  [DEPTH];
   logic [WW-1:0] ent_addr_d  [DEPTH];
   logic [31:0]   ent_wdata_q [DEPTH];
   logic [31:0]   ent_wdata_d [DEPTH];
   logic [31:0]   ent_bweb_q  [DEPTH];
   logic [31:0]   ent_bweb_d  [DEPTH];

   logic          push;
   logic          pop;
   logic          flush_rise;
   logic [31:0]   conv_wdata;
   logic [31:0]   conv_bweb;
   logic          addr_hit;

   // Only the word address of a load and the size bits of funct3 matter.
   logic          unused_bits;
   assign unused_bits = ^{st_funct3[2], ld_addr[1:0]};

   assign count = count_q;

   // Handshake and event decode for this cycle.
   always_comb begin
      st_ready   = (count_q < CW'(DEPTH)) && (state_q != ST_FLUSH);
      push       = st_valid && st_ready;
      pop        = (count_q != '0) && mem_grant;
      flush_rise = flush_req && !flush_prev_q;
      drain_done = (state_q == ST_FLUSH) && (count_q == '0);
   end

   // Align store data to its byte lanes and build the active-low write mask.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
      conv_wdata = st_data;
      conv_bweb  = '0;
      casez ({st_funct3[1:0], st_addr[1:0]})
         4'b00??: begin
            conv_wdata = {24'b0, st_data[7:0]} << {st_addr[1:0], 3'b000};
            conv_bweb  = ~(32'h0000_00FF << {st_addr[1:0], 3'b000});
         end
         4'b0100: begin
            conv_wdata = {16'b0, st_data[15:0]};
            conv_bweb  = 32'hFFFF_0000;
         end
         4'b0110: begin
            conv_wdata = {st_data[15:0], 16'b0};
            conv_bweb  = 32'h0000_FFFF;
         end
         default: ;
      endcase
   end

   // FIFO pointer, occupancy and entry updates.
   always_comb begin
      head_d       = head_q;
      tail_d       = tail_q;
      valid_d      = valid_q;
      ent_addr_d   = ent_addr_q;
      ent_wdata_d  = ent_wdata_q;
      ent_bweb_d   = ent_bweb_q;
      flush_prev_d = flush_req;

      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      if (push) begin
         valid_d[tail_q]     = 1'b1;
         ent_addr_d[tail_q]  = st_addr[ADDR_W-1:2];
         ent_wdata_d[tail_q] = conv_wdata;
         ent_bweb_d[tail_q]  = conv_bweb;
         tail_d              = tail_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Drain/flush state machine.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (flush_rise)  state_d = ST_FLUSH;
            else if (push)   state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (flush_rise)
               state_d = ST_FLUSH;
            else if (pop && !push && (count_q == CW'(1)))
               state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            if (count_q == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Word-address hazard between a load in MEM and any buffered or incoming store.
   always_comb begin
      addr_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (ent_addr_q[i] == ld_addr[ADDR_W-1:2])) addr_hit = 1'b1;
      end
      if (push && (st_addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) addr_hit = 1'b1;
      ld_stall = ld_check_valid && addr_hit;
   end

   // SRAM write port driven straight from the head entry.
   always_comb begin
      mem_web   = 1'b1;
      mem_bweb  = 32'hFFFF_FFFF;
      mem_addr  = '0;
      mem_wdata = '0;
      if (count_q != '0) begin
         mem_web   = 1'b0;
         mem_bweb  = ent_bweb_q[head_q];
         mem_addr  = {ent_addr_q[head_q], 2'b00};
         mem_wdata = ent_wdata_q[head_q];
      end
   end

   // Control state registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         valid_q      <= '0;
         flush_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         valid_q      <= valid_d;
         flush_prev_q <= flush_prev_d;
      end
   end

   // Entry payload storage.
   always_ff @(posedge clk) begin
      // NOTE: payload arrays are not reset; valid_q and count_q alone decide whether an entry is ever used.
      ent_addr_q  <= ent_addr_d;
      ent_wdata_q <= ent_wdata_d;
      ent_bweb_q  <= ent_bweb_d;
   end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
- Store buffer plus drain scheduler between the MEM stage and the single-port data SRAM.
- Accepts stores from the pipeline and converts each one to lane-aligned write data and an active-low bit-write mask at enqueue.
- Queues the converted stores in a FIFO and drains them to the SRAM whenever the load path does not hold the port.
- Provides load-hazard stall detection and a flush/fence drain handshake.

Parameters:
DEPTH, 4, number of buffer entries; power of two, at least 2
ADDR_W, 32, address width in bits

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
st_valid  in  1  store request from MEM stage
st_ready  out  1  buffer can accept a store this cycle
st_funct3  in  3  RISC-V store funct3 (SB=000, SH=001, SW=010)
st_addr  in  ADDR_W  store byte address
st_data  in  32  store source data, unshifted
ld_check_valid  in  1  a load is in MEM this cycle
ld_addr  in  ADDR_W  load byte address
ld_stall  out  1  load must stall because of a word-address hazard
flush_req  in  1  fence/flush request; level signal, sampled when it rises
drain_done  out  1  one-cycle pulse when a flush completes
mem_grant  in  1  SRAM port is free for the buffer this cycle (loads have priority)
mem_web  out  1  SRAM write enable, active low
mem_bweb  out  32  SRAM bit write enable, active low (0 = write that bit)
mem_addr  out  ADDR_W  SRAM address, word-aligned (bits [1:0] = 0)
mem_wdata  out  32  SRAM write data
count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset: all entries invalid, head/tail/count = 0, FSM in IDLE, st_ready=1, ld_stall=0, drain_done=0, mem_web=1, mem_bweb=32'hFFFFFFFF, mem_addr=0, mem_wdata=0. A reset that arrives mid-drain or mid-flush discards all entries with no further writes.
- Enqueue happens on a clock edge where st_valid && st_ready.
- Conversion at enqueue is keyed by {funct3[1:0], addr[1:0]}:
  - SB, offset k: wdata = data[7:0] << 8k; bweb has byte k = 00, all other bits 1.
  - SH, offset 0: wdata = {16'b0, data[15:0]}; bweb = 32'hFFFF0000.
  - SH, offset 2: wdata = {data[15:0], 16'b0}; bweb = 32'h0000FFFF.
  - All other codes (SW, misaligned SH, funct3[1:0]=11): wdata = data; bweb = 0.
  - Each entry stores addr[ADDR_W-1:2], wdata and bweb.
- st_ready = (count < DEPTH) && state != FLUSH. A full buffer does not accept a store even when a pop occurs in the same cycle.
- Drain is combinational from the head entry:
  - When count > 0, mem_web=0, mem_addr={head_addr,2'b00}, and mem_wdata/mem_bweb come from the head entry.
  - When count = 0, outputs hold their idle values.
  - Pop occurs on the edge where count > 0 && mem_grant. Without mem_grant the head is held and its outputs stay stable.
  - Earliest write is the cycle after enqueue, so latency from enqueue to write is 1 cycle minimum.
  - Writes occur strictly in FIFO order.
- Simultaneous enqueue and pop: count is unchanged, and head and tail both advance, wrapping modulo DEPTH.
- ld_stall = ld_check_valid && (ld_addr[ADDR_W-1:2] matches any valid entry, OR matches the store being accepted this cycle).
  - The match is on the word address regardless of byte lanes.
  - The entry popped this cycle still counts as a match.
- FSM states:
  - IDLE: count = 0.
  - DRAIN: count > 0, no flush pending.
  - FLUSH: flush pending.
- FSM transitions:
  - IDLE -> DRAIN when an enqueue occurs.
  - DRAIN -> IDLE when the pop empties the buffer with no enqueue.
  - IDLE or DRAIN -> FLUSH on a flush_req rising edge, detected with a registered previous value.
  - In FLUSH, no enqueues are accepted. When count reaches 0, drain_done pulses for 1 cycle and the FSM enters IDLE.
  - flush_req rising while in IDLE: FSM enters FLUSH with count = 0, so drain_done pulses the next cycle.
  - If flush_req is still high after completion, no new flush starts until the signal falls and rises again.

Test Plan:
- SB sequence: addr 0x100..0x103, data 0xA5, mem_grant=1 -> four writes to 0x100 with bweb FFFFFF00, FFFF00FF, FF00FFFF, 00FFFFFF and wdata 0xA5 in lanes 0..3; the first write occurs the cycle after the first enqueue.
- SH at 0x202, data 0x1234BEEF -> mem_addr 0x200, wdata 0xBEEF0000, bweb 0x0000FFFF. SH at 0x201 -> treated as a word: bweb 0, wdata 0x1234BEEF.
- Full/back-pressure: mem_grant=0, five SW stores -> st_ready drops after 4 and count=4. Then mem_grant=1 -> entries drain in order, with enqueue and pop in the same cycle keeping count constant.
- Hazard: SW at 0x300 buffered with mem_grant=0, then a load at 0x302 -> ld_stall=1; a load at 0x304 -> ld_stall=0; after the pop, a load at 0x302 -> ld_stall=0.
- Flush: 3 entries with mem_grant toggling, flush_req rising -> st_ready=0 until empty, a single drain_done pulse, then st_ready=1. Flush_req rising while empty -> drain_done on the next cycle.
- Reset mid-drain: 2 entries, rst=1 for one cycle -> count=0, mem_web=1, mem_bweb=FFFFFFFF, and no further writes.
